// File: rtl/ondra_kbd_pkg.sv
// ondra_kbd_pkg
//   Shared definitions for the Ondra SPO186 keyboard matrix block: matrix
//   geometry, FSM state type, keymap entry type and the KEYMAP function that
//   maps a PS/2 {extended, scancode} pair onto a matrix position.
//   Optional feature macro used by the block: ONDRA_KBD_JOY_EN.
package ondra_kbd_pkg;

    localparam int COLS      = 10;
    localparam int ROWS      = 5;
    localparam int JOY_COL   = 9;
    localparam int SHIFT_COL = 8;
    localparam int SHIFT_ROW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        APPLY  = 2'd2
    } kbd_state_t;

    // is_alias marks keys that the Ondra only produces together with SHIFT
    typedef struct packed {
        logic       hit;
        logic       is_alias;
        logic [3:0] col;
        logic [2:0] row;
    } keymap_t;

    function automatic keymap_t key_at(input logic is_alias, input logic [3:0] col,
                                       input logic [2:0] row);
        keymap_t e;
        e.hit      = 1'b1;
        e.is_alias = is_alias;
        e.col      = col;
        e.row      = row;
        return e;
    endfunction

    // Column 9 rows 0..3 double as the joystick directions, so the arrows live
    // there; LShift (12) is the real SHIFT key at column 8 row 4.
    function automatic keymap_t KEYMAP(input logic ext, input logic [7:0] code);
        keymap_t e;
        case ({ext, code})
            9'h01C: e = key_at(1'b0, 4'd0, 3'd0);
            9'h01B: e = key_at(1'b0, 4'd0, 3'd1);
            9'h023: e = key_at(1'b0, 4'd0, 3'd2);
            9'h02B: e = key_at(1'b0, 4'd0, 3'd3);
            9'h034: e = key_at(1'b0, 4'd0, 3'd4);
            9'h015: e = key_at(1'b0, 4'd1, 3'd0);
            9'h01D: e = key_at(1'b0, 4'd1, 3'd1);
            9'h024: e = key_at(1'b0, 4'd1, 3'd2);
            9'h02D: e = key_at(1'b0, 4'd1, 3'd3);
            9'h02C: e = key_at(1'b0, 4'd1, 3'd4);
            9'h016: e = key_at(1'b0, 4'd2, 3'd0);
            9'h01E: e = key_at(1'b0, 4'd2, 3'd1);
            9'h026: e = key_at(1'b0, 4'd2, 3'd2);
            9'h025: e = key_at(1'b0, 4'd2, 3'd3);
            9'h02E: e = key_at(1'b0, 4'd2, 3'd4);
            9'h01A: e = key_at(1'b0, 4'd3, 3'd0);
            9'h022: e = key_at(1'b0, 4'd3, 3'd1);
            9'h021: e = key_at(1'b0, 4'd3, 3'd2);
            9'h02A: e = key_at(1'b0, 4'd3, 3'd3);
            9'h032: e = key_at(1'b0, 4'd3, 3'd4);
            9'h033: e = key_at(1'b0, 4'd4, 3'd0);
            9'h03B: e = key_at(1'b0, 4'd4, 3'd1);
            9'h042: e = key_at(1'b0, 4'd4, 3'd2);
            9'h04B: e = key_at(1'b0, 4'd4, 3'd3);
            9'h05A: e = key_at(1'b0, 4'd4, 3'd4);
            9'h035: e = key_at(1'b0, 4'd5, 3'd0);
            9'h03C: e = key_at(1'b0, 4'd5, 3'd1);
            9'h043: e = key_at(1'b0, 4'd5, 3'd2);
            9'h044: e = key_at(1'b0, 4'd5, 3'd3);
            9'h04D: e = key_at(1'b0, 4'd5, 3'd4);
            9'h036: e = key_at(1'b0, 4'd6, 3'd0);
            9'h03D: e = key_at(1'b0, 4'd6, 3'd1);
            9'h03E: e = key_at(1'b0, 4'd6, 3'd2);
            9'h046: e = key_at(1'b0, 4'd6, 3'd3);
            9'h045: e = key_at(1'b0, 4'd6, 3'd4);
            9'h031: e = key_at(1'b0, 4'd7, 3'd0);
            9'h03A: e = key_at(1'b0, 4'd7, 3'd1);
            9'h041: e = key_at(1'b0, 4'd7, 3'd2);
            9'h049: e = key_at(1'b0, 4'd7, 3'd3);
            9'h029: e = key_at(1'b0, 4'd7, 3'd4);
            9'h014: e = key_at(1'b0, 4'd8, 3'd0);
            9'h011: e = key_at(1'b0, 4'd8, 3'd1);
            9'h066: e = key_at(1'b0, 4'd8, 3'd2);
            9'h076: e = key_at(1'b0, 4'd8, 3'd3);
            9'h012: e = key_at(1'b0, 4'd8, 3'd4);
            9'h174: e = key_at(1'b1, 4'd9, 3'd0);
            9'h16B: e = key_at(1'b1, 4'd9, 3'd1);
            9'h172: e = key_at(1'b1, 4'd9, 3'd2);
            9'h175: e = key_at(1'b1, 4'd9, 3'd3);
            9'h00D: e = key_at(1'b0, 4'd9, 3'd4);
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ondra_kbd_matrix_lookup.sv
// ondra_kbd_lookup
//   Registered keymap ROM: one-cycle latency from addr to entry.
//   Ports: clk_sys (clock), reset (async, active-high),
//          addr[8:0] = {extended, scancode}, entry = keymap_t result.
module ondra_kbd_lookup
    import ondra_kbd_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [8:0] addr,
    output keymap_t    entry
);

    // ROM read register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            entry <= '0;
        end else begin
            entry <= KEYMAP(addr[8], addr[7:0]);
        end
    end

endmodule

// File: rtl/ondra_kbd_matrix.sv
// ondra_kbd_matrix
//   Turns hps_io ps2_key events into the Ondra SPO186 10x5 key matrix.
//   Ports: clk_sys (8 MHz), reset (async, active-high),
//          ps2_key[10:0] = {toggle strobe, pressed, extended, scancode},
//          col_sel[3:0] column scanned by the CPU, row_n[4:0] active-low rows,
//          any_key (any matrix bit set), evt_drop (event discarded pulse),
//          joy[4:0] {fire,up,down,left,right} only when ONDRA_KBD_JOY_EN is defined.
//   With ONDRA_KBD_JOY_EN the synchronized joystick bits are ORed into column
//   JOY_COL (bit i -> row i); without it that column is keyboard only.
module ondra_kbd_matrix
    import ondra_kbd_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [3:0]  col_sel,
`ifdef ONDRA_KBD_JOY_EN
    input  logic [4:0]  joy,
`endif
    output logic [4:0]  row_n,
    output logic        any_key,
    output logic        evt_drop
);

    logic                       old_stb_r;
    logic                       evt_s;
    logic [9:0]                 evt_word_s;

    kbd_state_t                 state_r;
    kbd_state_t                 next_state_s;
    logic [9:0]                 cur_r;
    logic [9:0]                 pend_r;
    logic                       pend_valid_r;

    logic                       load_cur_s;
    logic                       cur_from_pend_s;
    logic                       load_pend_s;
    logic                       clear_pend_s;
    logic                       drop_s;
    logic                       apply_s;

    keymap_t                    map_s;
    logic [COLS-1:0][ROWS-1:0]  matrix_r;
    logic [COLS-1:0][ROWS-1:0]  view_s;
    logic [ROWS-1:0]            col_bits_s;
    logic [1:0]                 alias_cnt_r;
    logic                       old_bit_s;

    // A strobe toggle relative to last cycle marks a new event
    assign evt_s      = ps2_key[10] ^ old_stb_r;
    assign evt_word_s = ps2_key[9:0];

    // Strobe history; reset loads the current strobe so nothing replays afterwards
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            old_stb_r <= ps2_key[10];
        end else begin
            old_stb_r <= ps2_key[10];
        end
    end

    ondra_kbd_lookup u_lookup (
        .clk_sys (clk_sys),
        .reset   (reset),
        .addr    (cur_r[8:0]),
        .entry   (map_s)
    );

    // FSM state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state plus event routing between current slot and pending buffer
    always_comb begin
        next_state_s    = state_r;
        load_cur_s      = 1'b0;
        cur_from_pend_s = 1'b0;
        load_pend_s     = 1'b0;
        clear_pend_s    = 1'b0;
        drop_s          = 1'b0;
        apply_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_valid_r) begin
                    next_state_s    = LOOKUP;
                    load_cur_s      = 1'b1;
                    cur_from_pend_s = 1'b1;
                    clear_pend_s    = 1'b1;
                    load_pend_s     = evt_s;
                end else if (evt_s) begin
                    next_state_s = LOOKUP;
                    load_cur_s   = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOOKUP: begin
                next_state_s = APPLY;
                if (evt_s && !pend_valid_r) begin
                    load_pend_s = 1'b1;
                end else if (evt_s) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = 1'b0;
                end
            end
            APPLY: begin
                apply_s = 1'b1;
                if (pend_valid_r) begin
                    // Pending is served first; a simultaneous new event has nowhere to go
                    next_state_s    = LOOKUP;
                    load_cur_s      = 1'b1;
                    cur_from_pend_s = 1'b1;
                    clear_pend_s    = 1'b1;
                    drop_s          = evt_s;
                end else if (evt_s) begin
                    // Event arriving while leaving APPLY goes straight into the work slot
                    next_state_s = LOOKUP;
                    load_cur_s   = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Current event slot and one-entry pending buffer
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cur_r        <= 10'd0;
            pend_r       <= 10'd0;
            pend_valid_r <= 1'b0;
        end else begin
            if (load_cur_s) begin
                cur_r <= cur_from_pend_s ? pend_r : evt_word_s;
            end
            if (load_pend_s) begin
                pend_r       <= evt_word_s;
                pend_valid_r <= 1'b1;
            end else if (clear_pend_s) begin
                pend_valid_r <= 1'b0;
            end
        end
    end

    assign old_bit_s = matrix_r[map_s.col][map_s.row];

    // Key matrix and shifted-alias refcount; the refcount only moves on real
    // up/down transitions so typematic repeats cannot inflate it
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            matrix_r    <= '0;
            alias_cnt_r <= 2'd0;
        end else if (apply_s && map_s.hit) begin
            matrix_r[map_s.col][map_s.row] <= cur_r[9];
            if (map_s.is_alias) begin
                if (cur_r[9] && !old_bit_s && (alias_cnt_r != 2'd3)) begin
                    alias_cnt_r <= alias_cnt_r + 2'd1;
                end else if (!cur_r[9] && old_bit_s && (alias_cnt_r != 2'd0)) begin
                    alias_cnt_r <= alias_cnt_r - 2'd1;
                end
            end
        end
    end

`ifdef ONDRA_KBD_JOY_EN
    logic [4:0] joy_meta_r;
    logic [4:0] joy_sync_r;

    // Two-flop synchronizer for the asynchronous joystick inputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            joy_meta_r <= 5'd0;
            joy_sync_r <= 5'd0;
        end else begin
            joy_meta_r <= joy;
            joy_sync_r <= joy_meta_r;
        end
    end
`endif

    // Visible matrix: stored keys plus alias-driven SHIFT and joystick overlay
    always_comb begin
        view_s = matrix_r;
        view_s[SHIFT_COL][SHIFT_ROW] = matrix_r[SHIFT_COL][SHIFT_ROW] | (alias_cnt_r != 2'd0);
`ifdef ONDRA_KBD_JOY_EN
        view_s[JOY_COL] = matrix_r[JOY_COL] | joy_sync_r;
`endif
        if (col_sel < 4'(COLS)) begin
            col_bits_s = view_s[col_sel];
        end else begin
            col_bits_s = 5'd0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            row_n    <= 5'h1F;
            any_key  <= 1'b0;
            evt_drop <= 1'b0;
        end else begin
            row_n    <= ~col_bits_s;
            any_key  <= |view_s;
            evt_drop <= drop_s;
        end
    end

endmodule

// File: tb/tb_ondra_kbd_matrix.sv
// tb_ondra_kbd_matrix
//   Self-checking bench: directed scenarios plus randomized key bursts compared
//   against a key-position reference model kept here.
module tb_ondra_kbd_matrix;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [3:0]  col_sel;
    logic [4:0]  row_n;
    logic        any_key;
    logic        evt_drop;
`ifdef ONDRA_KBD_JOY_EN
    logic [4:0]  joy;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int drop_seen = 0;
    int exp_drops = 0;

    // Reference model: key position table (index = col*5 + row) and state
    logic [8:0] key_addr [0:49] = '{
        9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034,
        9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,
        9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
        9'h01A, 9'h022, 9'h021, 9'h02A, 9'h032,
        9'h033, 9'h03B, 9'h042, 9'h04B, 9'h05A,
        9'h035, 9'h03C, 9'h043, 9'h044, 9'h04D,
        9'h036, 9'h03D, 9'h03E, 9'h046, 9'h045,
        9'h031, 9'h03A, 9'h041, 9'h049, 9'h029,
        9'h014, 9'h011, 9'h066, 9'h076, 9'h012,
        9'h174, 9'h16B, 9'h172, 9'h175, 9'h00D
    };
    logic [8:0] unmapped [0:5] = '{9'h000, 9'h0FF, 9'h11C, 9'h059, 9'h075, 9'h114};
    bit         mdl_key [0:49];
    int         mdl_alias = 0;
    logic [4:0] joy_v = 5'd0;

    ondra_kbd_matrix dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .col_sel  (col_sel),
`ifdef ONDRA_KBD_JOY_EN
        .joy      (joy),
`endif
        .row_n    (row_n),
        .any_key  (any_key),
        .evt_drop (evt_drop)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (evt_drop === 1'b1) drop_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int find_key(input logic [8:0] a);
        for (int i = 0; i < 50; i++) begin
            if (key_addr[i] == a) return i;
        end
        return -1;
    endfunction

    function automatic void mdl_apply(input logic p, input logic [8:0] a);
        int idx;
        idx = find_key(a);
        if (idx < 0) return;
        if (idx >= 45 && idx <= 48) begin
            if (p && !mdl_key[idx] && mdl_alias < 3) mdl_alias++;
            else if (!p && mdl_key[idx] && mdl_alias > 0) mdl_alias--;
        end
        mdl_key[idx] = p;
    endfunction

    function automatic void mdl_clear();
        for (int i = 0; i < 50; i++) mdl_key[i] = 1'b0;
        mdl_alias = 0;
    endfunction

    function automatic logic [4:0] mdl_row_n(input int c);
        logic [4:0] b;
        b = 5'd0;
        if (c >= 10) return 5'h1F;
        for (int r = 0; r < 5; r++) begin
            b[r] = mdl_key[c*5 + r];
        end
        if (c == 8 && mdl_alias != 0) b[4] = 1'b1;
        if (c == 9) b = b | joy_v;
        return ~b;
    endfunction

    function automatic logic mdl_any();
        logic a;
        a = 1'b0;
        for (int c = 0; c < 10; c++) a = a | (mdl_row_n(c) != 5'h1F);
        return a;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic p, input logic [8:0] a);
        @(posedge clk_sys);
        #1;
        ps2_key = {~ps2_key[10], p, a};
    endtask

    task automatic peek(input logic [3:0] c, output logic [4:0] v);
        col_sel = c;
        @(posedge clk_sys);
        #1;
        v = row_n;
    endtask

    task automatic scan_all(input string tag);
        logic [4:0] v;
        for (int c = 0; c < 11; c++) begin
            peek((c < 10) ? 4'(c) : 4'hF, v);
            check_eq($sformatf("%s_col%0d", tag, c), {27'd0, v}, {27'd0, mdl_row_n(c)});
        end
        check_eq({tag, "_any"}, {31'd0, any_key}, {31'd0, mdl_any()});
    endtask

    initial begin
        logic [4:0] v;
        int         n;
        int         idx;
        logic [8:0] a [0:2];
        logic       p [0:2];

        reset   = 1'b1;
        ps2_key = 11'd0;
        col_sel = 4'd0;
`ifdef ONDRA_KBD_JOY_EN
        joy = 5'd0;
`endif
        mdl_clear();
        #2;
        check_eq("rst_row_n", {27'd0, row_n}, 32'h1F);
        check_eq("rst_any", {31'd0, any_key}, 32'd0);
        check_eq("rst_drop", {31'd0, evt_drop}, 32'd0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        scan_all("after_reset");

        // Press A: visible exactly three edges after the event edge
        col_sel = 4'd0;
        wait_cyc(1);
        send(1'b1, 9'h01C);
        mdl_apply(1'b1, 9'h01C);
        wait_cyc(3);
        check_eq("a_not_yet", {27'd0, row_n}, 32'h1F);
        wait_cyc(1);
        check_eq("a_pressed", {27'd0, row_n}, 32'h1E);
        check_eq("a_any", {31'd0, any_key}, 32'd1);
        send(1'b0, 9'h01C);
        mdl_apply(1'b0, 9'h01C);
        wait_cyc(5);
        check_eq("a_released", {27'd0, row_n}, 32'h1F);
        // Release of a never-pressed key is harmless
        send(1'b0, 9'h01B);
        mdl_apply(1'b0, 9'h01B);
        wait_cyc(5);
        scan_all("rel_unpressed");

        // Arrow aliases drive SHIFT through the refcount
        send(1'b1, 9'h175);
        mdl_apply(1'b1, 9'h175);
        wait_cyc(5);
        peek(4'd8, v);
        check_eq("up_shift", {27'd0, v}, 32'h0F);
        peek(4'd9, v);
        check_eq("up_arrow", {27'd0, v}, 32'h17);
        send(1'b1, 9'h172);
        mdl_apply(1'b1, 9'h172);
        send(1'b1, 9'h172);
        mdl_apply(1'b1, 9'h172);
        wait_cyc(8);
        send(1'b0, 9'h175);
        mdl_apply(1'b0, 9'h175);
        wait_cyc(5);
        peek(4'd8, v);
        check_eq("shift_held_by_down", {27'd0, v}, 32'h0F);
        send(1'b0, 9'h172);
        mdl_apply(1'b0, 9'h172);
        wait_cyc(5);
        peek(4'd8, v);
        check_eq("shift_released", {27'd0, v}, 32'h1F);
        scan_all("alias");

        // Three back-to-back strobes: third is dropped
        send(1'b1, 9'h01C);
        send(1'b1, 9'h01B);
        send(1'b1, 9'h023);
        mdl_apply(1'b1, 9'h01C);
        mdl_apply(1'b1, 9'h01B);
        exp_drops++;
        wait_cyc(10);
        check_eq("burst_drop_cnt", drop_seen, exp_drops);
        peek(4'd0, v);
        check_eq("burst_col0", {27'd0, v}, 32'h1C);

        // Unmapped code changes nothing and is not a drop
        send(1'b1, 9'h000);
        wait_cyc(6);
        check_eq("unmapped_drop_cnt", drop_seen, exp_drops);
        scan_all("unmapped");

        // Randomized bursts of 1..3 consecutive events
        for (int it = 0; it < 120; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                idx = $urandom_range(0, 55);
                a[k] = (idx < 50) ? key_addr[idx] : unmapped[idx - 50];
                p[k] = 1'($urandom_range(0, 1));
                send(p[k], a[k]);
            end
            for (int k = 0; k < n && k < 2; k++) mdl_apply(p[k], a[k]);
            if (n == 3) exp_drops++;
            wait_cyc(8);
            check_eq($sformatf("rnd%0d_drops", it), drop_seen, exp_drops);
            if (it % 4 == 0) scan_all($sformatf("rnd%0d", it));
        end
        scan_all("rnd_final");

`ifdef ONDRA_KBD_JOY_EN
        col_sel = 4'd9;
        wait_cyc(1);
        joy   = 5'b10000;
        joy_v = 5'b10000;
        wait_cyc(3);
        check_eq("joy_fire_row4", {31'd0, row_n[4]}, 32'd0);
        scan_all("joy");
        joy   = 5'd0;
        joy_v = 5'd0;
        wait_cyc(4);
`endif

        // Reset while an event sits in APPLY: abandoned, matrix cleared
        send(1'b1, 9'h034);
        wait_cyc(2);
        reset = 1'b1;
        #1;
        check_eq("midapply_row_n", {27'd0, row_n}, 32'h1F);
        mdl_clear();
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(6);
        scan_all("midapply");
        check_eq("final_drops", drop_seen, exp_drops);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
